xdma_grant_receiver: RTL and testbench
======================================

Name: xdma_grant_receiver

Overview:
- Initiator-side counterpart of the receiver's grant issuer.
- Holds one outstanding local task that was sent to a remote cluster, and consumes incoming to-remote grant beats.
- Matches a grant to the task by dma_id and by destination cluster, then issues a start handshake to the local data mover. It waits for transfer completion before accepting the next task.
- Sits between the xDMA frontend's task issue path and the AXI-side grant ingress.

Parameters:
- addr_t, logic, address type, matching the grant's `from` field.
- grant_t, logic, to-remote grant struct with fields dma_id, from, reserved.
- DmaIdWidth, 8, width of dma_id.
- ClusterSize, 32'h0004_0000, cluster address window size; must be a power of two.
- TimeoutCycles, 1024, cycles allowed in WAIT_GRANT. Used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cluster_base_addr_i  in  addr_t  own cluster base address; static
- task_valid_i  in  1  local task awaiting grant
- task_ready_o  out  1  task accepted
- task_dma_id_i  in  DmaIdWidth  id of the task
- grant_i  in  grant_t  incoming grant beat
- grant_valid_i  in  1  grant valid
- grant_ready_o  out  1  grant ready
- start_valid_o  out  1  request to start the data transfer
- start_ready_i  in  1  data mover accepts the start
- start_dma_id_o  out  DmaIdWidth  id of the granted task
- finish_i  in  1  single-cycle pulse when the granted transfer completes
- busy_o  out  1  a task is in flight
- timeout_o  out  1  single-cycle pulse: grant wait expired
- drop_cnt_o  out  8  count of discarded grants; saturates at 255

Behaviour:
- Reset values (asynchronous, while rst_i=1):
  - state=IDLE; pending register empty; drop_cnt_o=0; timeout counter=0.
  - start_valid_o=0, timeout_o=0, busy_o=0, start_dma_id_o=0.
  - task_ready_o=1 and grant_ready_o=1 (follow from IDLE with pending empty).
- Reset mid-operation discards the task and the pending grant, with no start or timeout emitted.
- Cluster hit: (grant_i.from & ~(ClusterSize-1)) == cluster_base_addr_i.
  - Grants failing the cluster check are accepted and dropped in every state (drop_cnt_o+1).
- Grant match: cluster hit AND grant_i.dma_id == registered task id (or task_dma_id_i during the IDLE accept cycle).
- States and transitions:
  - IDLE:
    - task_ready_o=1; grant_ready_o = !pending_valid.
    - Grant handshake without task handshake, cluster hit → store in pending.
    - Task handshake → register task id, then:
      - a pending entry with equal id → START; pending cleared.
      - a pending entry with different id → pending cleared, drop+1, WAIT_GRANT.
      - pending empty and a same-cycle matching grant → START.
      - same-cycle non-matching grant → drop+1, WAIT_GRANT.
      - otherwise → WAIT_GRANT.
  - WAIT_GRANT:
    - task_ready_o=0; grant_ready_o=1.
    - Matching grant → START next cycle.
    - Non-matching grant → drop+1, stay.
  - START:
    - start_valid_o=1 with start_dma_id_o = task id; hold until start_ready_i.
    - Handshake → WAIT_FINISH.
  - WAIT_FINISH:
    - finish_i=1 → IDLE.
- finish_i outside WAIT_FINISH is ignored.
- In START and WAIT_FINISH, grant_ready_o = !pending_valid; cluster-hit grants are stored in pending for the next task.
- busy_o = (state != IDLE). task_ready_o=0 outside IDLE.
- Latency:
  - task handshake to start_valid_o: ≥2 cycles via WAIT_GRANT, or exactly 1 cycle with a pending/simultaneous match.
  - grant handshake to start_valid_o: 1 cycle.
- drop_cnt_o saturates at 255 with no wrap. An increment on the same cycle as saturation holds at 255.
- Outputs are registered state-decoded, except task_ready_o and grant_ready_o, which are combinational from state/pending only, with no dependence on valid inputs.

Optional Feature:
- Macro XDMA_GRANT_RX_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT_GRANT and increments each WAIT_GRANT cycle without a matching grant.
  - When the counter == TimeoutCycles-1 with no match: timeout_o=1 for one cycle, task dropped, → IDLE.
  - A matching grant in the same cycle wins; no timeout is raised.
- Undefined: no counter logic; timeout_o tied 0; WAIT_GRANT waits indefinitely.

Test Plan:
- Basic grant path:
  - Stimulus: base=0x1000_0000, ClusterSize=0x4_0000; task id=5; 3 cycles later grant{dma_id=5, from=0x1000_0200}; start_ready_i=1.
  - Required: start_valid_o high exactly 1 cycle after the grant with start_dma_id_o=5; finish_i pulse → busy_o=0 next cycle.
- Filtering:
  - Stimulus: in WAIT_GRANT for id=5, send grant id=6 (hit), then grant id=5 with from=0x2000_0000 (miss), then grant id=5 (hit).
  - Required: drop_cnt_o=2; start only after the third grant.
- Early grant:
  - Stimulus: grant id=9 (hit) while IDLE; then grant_ready_o=0; task id=9.
  - Required: start_valid_o 1 cycle after the task handshake; pending cleared; grant_ready_o=1.
- Start backpressure:
  - Stimulus: start_ready_i=0 for 4 cycles.
  - Required: start_valid_o and start_dma_id_o stable; finish_i pulses before the handshake are ignored.
- Timeout (XDMA_GRANT_RX_TIMEOUT_EN, TimeoutCycles=8):
  - Stimulus: no grant; separately, a matching grant on the 8th WAIT_GRANT cycle.
  - Required: timeout_o pulse on the 8th WAIT_GRANT cycle, then IDLE; in the second case START with no timeout.
- Saturation/reset:
  - Stimulus: 300 miss grants → drop_cnt_o=255; rst_i pulse during START.
  - Required: all outputs return to the reset values above.

Source files
------------

// File: rtl/xdma_grant_receiver.sv
// xdma_grant_receiver: initiator-side grant receiver for the xDMA frontend.
// Holds one outstanding remote task. Incoming to-remote grants are matched by
// dma_id and destination cluster, then a start handshake goes to the local
// data mover. A grant that hits this cluster before its task arrives is
// parked in a one-entry pending register.
// Optional grant-wait timeout: define XDMA_GRANT_RX_TIMEOUT_EN.

package xdma_grant_receiver_pkg;
  typedef logic [31:0] addr_t;
  typedef struct packed {
    logic [7:0]  dma_id;
    addr_t       from;
    logic [23:0] reserved;
  } grant_t;
endpackage

module xdma_grant_receiver #(
  parameter type         addr_t        = xdma_grant_receiver_pkg::addr_t,
  parameter type         grant_t       = xdma_grant_receiver_pkg::grant_t,
  parameter int unsigned DmaIdWidth    = 8,
  parameter logic [31:0] ClusterSize   = 32'h0004_0000,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  addr_t                 cluster_base_addr_i,
  input  logic                  task_valid_i,
  output logic                  task_ready_o,
  input  logic [DmaIdWidth-1:0] task_dma_id_i,
  input  grant_t                grant_i,
  input  logic                  grant_valid_i,
  output logic                  grant_ready_o,
  output logic                  start_valid_o,
  input  logic                  start_ready_i,
  output logic [DmaIdWidth-1:0] start_dma_id_o,
  input  logic                  finish_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [7:0]            drop_cnt_o
);

  localparam addr_t ClusterMask = ~(addr_t'(ClusterSize) - addr_t'(1));

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, START, WAIT_FINISH} state_t;

  state_t                state_q, state_d;
  logic [DmaIdWidth-1:0] task_id_q, task_id_d;
  logic [DmaIdWidth-1:0] pending_id_q, pending_id_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [DmaIdWidth-1:0] grant_id;
  logic                  cluster_hit;
  logic                  task_hs;
  logic                  grant_hs;
  logic                  drop_inc;
  logic [7:0]            drop_q;
  logic                  unused_grant_bits;

`ifdef XDMA_GRANT_RX_TIMEOUT_EN
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntWidth-1:0] LastCount = CntWidth'(TimeoutCycles - 1);

  logic [CntWidth-1:0] cnt_q;
  logic                cnt_inc;
  logic                timeout_d;
  logic                timeout_q;
`else
  logic                unused_timeout_cfg;
`endif

  assign grant_id          = DmaIdWidth'(grant_i.dma_id);
  assign cluster_hit       = (grant_i.from & ClusterMask) == cluster_base_addr_i;
  assign unused_grant_bits = ^grant_i.reserved;

  // Ready signals depend only on state and the pending slot, never on valids.
  always_comb begin
    task_ready_o  = (state_q == IDLE);
    grant_ready_o = (state_q == WAIT_GRANT) ? 1'b1 : !pending_valid_q;
  end

  assign task_hs  = task_valid_i && task_ready_o;
  assign grant_hs = grant_valid_i && grant_ready_o;

  // Next-state logic: task acceptance, grant matching, parking and dropping.
  always_comb begin
    state_d         = state_q;
    task_id_d       = task_id_q;
    pending_valid_d = pending_valid_q;
    pending_id_d    = pending_id_q;
    drop_inc        = 1'b0;
`ifdef XDMA_GRANT_RX_TIMEOUT_EN
    cnt_inc         = 1'b0;
    timeout_d       = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (task_hs) begin
          task_id_d = task_dma_id_i;
          if (pending_valid_q) begin
            pending_valid_d = 1'b0;
            if (pending_id_q == task_dma_id_i) begin
              state_d = START;
            end else begin
              drop_inc = 1'b1;
              state_d  = WAIT_GRANT;
            end
          end else if (grant_hs && cluster_hit && (grant_id == task_dma_id_i)) begin
            state_d = START;
          end else begin
            drop_inc = grant_hs;
            state_d  = WAIT_GRANT;
          end
        end else if (grant_hs) begin
          if (cluster_hit) begin
            pending_valid_d = 1'b1;
            pending_id_d    = grant_id;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      WAIT_GRANT: begin
        if (grant_hs && cluster_hit && (grant_id == task_id_q)) begin
          state_d = START;
        end else begin
          drop_inc = grant_hs;
`ifdef XDMA_GRANT_RX_TIMEOUT_EN
          if (cnt_q == LastCount) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
`endif
        end
      end
      START, WAIT_FINISH: begin
        if (grant_hs) begin
          if (cluster_hit) begin
            pending_valid_d = 1'b1;
            pending_id_d    = grant_id;
          end else begin
            drop_inc = 1'b1;
          end
        end
        if (state_q == START) begin
          if (start_ready_i) state_d = WAIT_FINISH;
        end else if (finish_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, task id and pending-grant registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      task_id_q       <= '0;
      pending_valid_q <= 1'b0;
      pending_id_q    <= '0;
    end else begin
      state_q         <= state_d;
      task_id_q       <= task_id_d;
      pending_valid_q <= pending_valid_d;
      pending_id_q    <= pending_id_d;
    end
  end

  // Saturating count of discarded grants.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q <= '0;
    end else if (drop_inc && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

`ifdef XDMA_GRANT_RX_TIMEOUT_EN
  // Grant-wait counter restarts whenever we are not waiting for a grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (state_q != WAIT_GRANT) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_o          = 1'b0;
`endif

  assign start_valid_o  = (state_q == START);
  assign start_dma_id_o = task_id_q;
  assign busy_o         = (state_q != IDLE);
  assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_xdma_grant_receiver.sv
// Testbench for xdma_grant_receiver: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_xdma_grant_receiver;
  import xdma_grant_receiver_pkg::*;

  localparam logic [31:0] Base  = 32'h1000_0000;
  localparam logic [31:0] CSize = 32'h0004_0000;
  localparam int          TO    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] base_addr;
  logic        task_valid, task_ready;
  logic [7:0]  task_dma_id;
  grant_t      grant;
  logic        grant_valid, grant_ready;
  logic        start_valid, start_ready;
  logic [7:0]  start_dma_id;
  logic        finish, busy, timeout;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xdma_grant_receiver #(.TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst), .cluster_base_addr_i(base_addr),
    .task_valid_i(task_valid), .task_ready_o(task_ready), .task_dma_id_i(task_dma_id),
    .grant_i(grant), .grant_valid_i(grant_valid), .grant_ready_o(grant_ready),
    .start_valid_o(start_valid), .start_ready_i(start_ready), .start_dma_id_o(start_dma_id),
    .finish_i(finish), .busy_o(busy), .timeout_o(timeout), .drop_cnt_o(drop_cnt)
  );

  // Reference model: one task slot with its progress, a queue of early grants.
  bit         m_held;      // task accepted and not yet finished or timed out
  bit         m_granted;   // grant matched, start not yet accepted
  bit         m_moving;    // start accepted, transfer in progress
  logic [7:0] m_task_id;
  int         early_q[$];
  int         m_drops;
  int         m_wait;
  bit         m_timeout;

  function automatic void model_reset();
    m_held = 0; m_granted = 0; m_moving = 0; m_task_id = 8'h00;
    early_q.delete(); m_drops = 0; m_wait = 0; m_timeout = 0;
  endfunction

  function automatic bit m_task_ready();
    return !m_held;
  endfunction

  function automatic bit m_grant_ready();
    if (m_held && !m_granted && !m_moving) return 1'b1;
    return early_q.size() == 0;
  endfunction

  function automatic void model_drop();
    m_drops = (m_drops < 255) ? m_drops + 1 : 255;
  endfunction

  function automatic void model_step(input bit tv, input logic [7:0] tid, input bit gv,
                                     input logic [7:0] gid, input logic [31:0] gfrom,
                                     input bit sr, input bit fin);
    bit t_hs, g_hs, hit;
    int p;
    t_hs = tv && m_task_ready();
    g_hs = gv && m_grant_ready();
    hit  = (gfrom & ~(CSize - 1)) == Base;
    m_timeout = 0;
    if (!m_held) begin
      if (t_hs) begin
        m_held = 1; m_task_id = tid; m_wait = 0;
        if (early_q.size() != 0) begin
          p = early_q.pop_front();
          if (p == int'(tid)) m_granted = 1;
          else model_drop();
        end else if (g_hs && hit && gid == tid) begin
          m_granted = 1;
        end else if (g_hs) begin
          model_drop();
        end
      end else if (g_hs) begin
        if (hit) early_q.push_back(int'(gid));
        else model_drop();
      end
    end else if (!m_granted && !m_moving) begin
      if (g_hs && hit && gid == m_task_id) begin
        m_granted = 1;
      end else begin
        if (g_hs) model_drop();
`ifdef XDMA_GRANT_RX_TIMEOUT_EN
        if (m_wait == TO - 1) begin
          m_timeout = 1; m_held = 0;
        end else begin
          m_wait++;
        end
`endif
      end
    end else begin
      if (g_hs) begin
        if (hit) early_q.push_back(int'(gid));
        else model_drop();
      end
      if (m_granted) begin
        if (sr) begin m_granted = 0; m_moving = 1; end
      end else if (fin) begin
        m_moving = 0; m_held = 0;
      end
    end
  endfunction

  // Drives one cycle of inputs, advances the model, and moves past the edge.
  task automatic cyc(input bit tv, input logic [7:0] tid, input bit gv, input logic [7:0] gid,
                     input logic [31:0] gfrom, input bit sr, input bit fin);
    task_valid = tv; task_dma_id = tid; grant_valid = gv;
    grant.dma_id = gid; grant.from = gfrom; grant.reserved = '0;
    start_ready = sr; finish = fin;
    model_step(tv, tid, gv, gid, gfrom, sr, fin);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    task_valid = 0; task_dma_id = 0; grant_valid = 0; grant = '0; start_ready = 0; finish = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    base_addr = Base;
    rst = 1'b1;
    task_valid = 0; task_dma_id = 0; grant_valid = 0; grant = '0; start_ready = 0; finish = 0;
    #2;
    checks++;
    if (start_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got sv=%b busy=%b to=%b exp 0 0 0", start_valid, busy, timeout);
    end
    checks++;
    if (start_dma_id !== 8'h00 || drop_cnt !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_counts got id=%h drop=%0d exp 00 0", start_dma_id, drop_cnt);
    end
    checks++;
    if (task_ready !== 1'b1 || grant_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready got tr=%b gr=%b exp 1 1", task_ready, grant_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    cyc(1, 8'd5, 0, 0, 0, 1, 0);
    checks++;
    if (busy !== 1'b1 || task_ready !== 1'b0 || start_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_accept got busy=%b tr=%b sv=%b exp 1 0 0", busy, task_ready, start_valid);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (start_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL basic_no_early_start got sv=%b exp 0", start_valid);
      end
    end
    cyc(0, 0, 1, 8'd5, Base + 32'h200, 1, 0);
    checks++;
    if (start_valid !== 1'b1 || start_dma_id !== 8'd5) begin
      failures++;
      $display("[TB] FAIL basic_start got sv=%b id=%0d exp 1 5", start_valid, start_dma_id);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if (start_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_handshake got sv=%b busy=%b exp 0 1", start_valid, busy);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_finish got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_filter();
    cyc(1, 8'd5, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'd6, Base + 32'h40, 0, 0);
    cyc(0, 0, 1, 8'd5, 32'h2000_0000, 0, 0);
    checks++;
    if (drop_cnt !== 8'd2 || start_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL filter_drops got drop=%0d sv=%b exp 2 0", drop_cnt, start_valid);
    end
    cyc(0, 0, 1, 8'd5, Base + 32'h3_FFFC, 0, 0);
    checks++;
    if (start_valid !== 1'b1 || start_dma_id !== 8'd5 || drop_cnt !== 8'd2) begin
      failures++;
      $display("[TB] FAIL filter_start got sv=%b id=%0d drop=%0d exp 1 5 2", start_valid, start_dma_id, drop_cnt);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_early_grant();
    cyc(0, 0, 1, 8'd9, Base + 32'h10, 0, 0);
    checks++;
    if (grant_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL early_parked got gr=%b busy=%b exp 0 0", grant_ready, busy);
    end
    cyc(1, 8'd9, 0, 0, 0, 0, 0);
    checks++;
    if (start_valid !== 1'b1 || start_dma_id !== 8'd9 || grant_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL early_start got sv=%b id=%0d gr=%b exp 1 9 1", start_valid, start_dma_id, grant_ready);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    cyc(1, 8'h33, 1, 8'h33, Base, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (start_valid !== 1'b1 || start_dma_id !== 8'h33 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_hold cyc=%0d got sv=%b id=%h busy=%b exp 1 33 1", i, start_valid, start_dma_id, busy);
      end
      cyc(0, 0, 0, 0, 0, 0, i[0]);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (start_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_wait_finish got sv=%b busy=%b exp 0 1", start_valid, busy);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_finish got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_timeout();
`ifdef XDMA_GRANT_RX_TIMEOUT_EN
    cyc(1, 8'd7, 0, 0, 0, 0, 0);
    for (int i = 1; i < TO; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (timeout !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL to_early cyc=%0d got to=%b busy=%b exp 0 1", i, timeout, busy);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_pulse got to=%b busy=%b exp 1 0", timeout, busy);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL to_single got to=%b exp 0", timeout);
    end
    cyc(1, 8'd7, 0, 0, 0, 0, 0);
    for (int i = 1; i < TO; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 8'd7, Base, 0, 0);
    checks++;
    if (timeout !== 1'b1 && start_valid === 1'b1 && start_dma_id === 8'd7) begin
    end else begin
      failures++;
      $display("[TB] FAIL to_grant_wins got to=%b sv=%b id=%0d exp 0 1 7", timeout, start_valid, start_dma_id);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
`else
    cyc(1, 8'd7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3 * TO; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (timeout !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL nto_wait cyc=%0d got to=%b busy=%b exp 0 1", i, timeout, busy);
      end
    end
    cyc(0, 0, 1, 8'd7, Base, 0, 0);
    checks++;
    if (start_valid !== 1'b1 || start_dma_id !== 8'd7) begin
      failures++;
      $display("[TB] FAIL nto_start got sv=%b id=%0d exp 1 7", start_valid, start_dma_id);
    end
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
`endif
  endtask

  task automatic test_random();
    bit          tv, gv, sr, fin;
    logic [7:0]  tid, gid;
    logic [31:0] gfrom;
    for (int i = 0; i < 500; i++) begin
      tv    = ($urandom % 3) == 0;
      tid   = 8'(1 + $urandom % 3);
      gv    = ($urandom % 2) == 0;
      gid   = 8'(1 + $urandom % 3);
      gfrom = (($urandom % 4) == 0) ? (32'h2000_0000 | ($urandom & 32'hFFFF))
                                    : (Base | ($urandom & 32'h3_FFFF));
      sr    = ($urandom % 2) == 0;
      fin   = ($urandom % 4) == 0;
      checks++;
      if (task_ready !== m_task_ready() || grant_ready !== m_grant_ready()) begin
        failures++;
        $display("[TB] FAIL rnd_ready cyc=%0d got tr=%b gr=%b exp %b %b", i, task_ready, grant_ready,
                 m_task_ready(), m_grant_ready());
      end
      cyc(tv, tid, gv, gid, gfrom, sr, fin);
      checks++;
      if (start_valid !== m_granted || start_dma_id !== m_task_id) begin
        failures++;
        $display("[TB] FAIL rnd_start cyc=%0d got sv=%b id=%0d exp %b %0d", i, start_valid, start_dma_id,
                 m_granted, m_task_id);
      end
      checks++;
      if (busy !== m_held || timeout !== m_timeout || drop_cnt !== 8'(m_drops)) begin
        failures++;
        $display("[TB] FAIL rnd_status cyc=%0d got busy=%b to=%b drop=%0d exp %b %b %0d", i, busy, timeout,
                 drop_cnt, m_held, m_timeout, m_drops);
      end
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    for (int i = 0; i < 200; i++) cyc(0, 0, 1, 8'(i), 32'h3000_0000 + 32'(i), 0, 0);
    checks++;
    if (drop_cnt !== 8'd200) begin
      failures++;
      $display("[TB] FAIL sat_mid got drop=%0d exp 200", drop_cnt);
    end
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, 8'(i), 32'h3000_0000 + 32'(i), 0, 0);
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("[TB] FAIL sat_hold got drop=%0d exp 255", drop_cnt);
    end
    cyc(1, 8'h44, 1, 8'h44, Base + 32'h10, 0, 0);
    cyc(0, 0, 1, 8'h55, Base + 32'h20, 0, 0);
    checks++;
    if (start_valid !== 1'b1 || grant_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_setup got sv=%b gr=%b exp 1 0", start_valid, grant_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (start_valid !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0 || start_dma_id !== 8'h00) begin
      failures++;
      $display("[TB] FAIL rst_mid_flags got sv=%b busy=%b to=%b id=%h exp 0 0 0 00", start_valid, busy,
               timeout, start_dma_id);
    end
    checks++;
    if (drop_cnt !== 8'h00 || task_ready !== 1'b1 || grant_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_state got drop=%0d tr=%b gr=%b exp 0 1 1", drop_cnt, task_ready, grant_ready);
    end
    grant_valid = 0; task_valid = 0; start_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (start_valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_after got sv=%b to=%b busy=%b exp 0 0 0", start_valid, timeout, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_early_grant();
    test_backpressure();
    test_timeout();
    test_random();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
